json_feedback_receiver: RTL

Receive-side counterpart to the JSON command sender. It deserialises the robot base's UART feedback stream (8N1, LSB first, idle high) and parses flat JSON objects such as {"T":1001,"L":-120,"R":35}. It extracts signed integer field values in order of appearance and presents them with a one-cycle valid strobe. It sits between the motor controller's TX line and the FPGA control logic that consumes odometry and status.

---
 rtl/json_feedback_receiver.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/json_feedback_receiver.sv
// UART (8N1) receiver plus flat-JSON integer extractor for the robot base feedback stream.
// Emits up to FIELDS_N saturated signed values per object with a one-cycle valid strobe.
module json_feedback_receiver #(
  parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
  parameter int BITS_N       = 8,
  parameter int FIELDS_N     = 3,
  parameter int VALUE_W      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                uart_in,
  output logic [FIELDS_N*VALUE_W-1:0]         values,
  output logic [$clog2(FIELDS_N+1)-1:0]       field_count,
  output logic                                valid,
  output logic                                frame_error,
  output logic                                busy
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam int BW = $clog2(BITS_N + 1);
  localparam int CW = $clog2(FIELDS_N + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(BITS_N - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIELDS_N);
  localparam logic [31:0]   POS_MAX   = 32'((1 << (VALUE_W - 1)) - 1);
  localparam logic [VALUE_W-1:0] NEG_MIN = {1'b1, {(VALUE_W-1){1'b0}}};
  localparam logic [31:0]   ACC_MAX   = 32'h7FFF_FFFF;

  // ---------------- UART receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t         rx_state;
  logic [1:0]        sync;
  logic              rx;
  logic [TW-1:0]     tmr;
  logic [BW-1:0]     bit_idx;
  logic [BITS_N-1:0] shreg;
  logic [BITS_N-1:0] rx_byte;
  logic              byte_strobe;
  logic              stop_err;

  assign rx = sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync        <= 2'b11;
      rx_state    <= RX_IDLE;
      tmr         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
    end else begin
      sync        <= {sync[0], uart_in};
      byte_strobe <= 1'b0;
      stop_err    <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          tmr <= '0;
          if (!rx) rx_state <= RX_START;
        end
        RX_START: begin
          if (tmr == HALF_LAST) begin
            tmr     <= '0;
            bit_idx <= '0;
            rx_state <= rx ? RX_IDLE : RX_DATA;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RX_DATA: begin
          if (tmr == BIT_LAST) begin
            tmr     <= '0;
            shreg   <= {rx, shreg[BITS_N-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_LAST) rx_state <= RX_STOP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RX_STOP: begin
          if (tmr == BIT_LAST) begin
            tmr <= '0;
            if (rx) begin
              rx_byte     <= shreg;
              byte_strobe <= 1'b1;
              rx_state    <= RX_IDLE;
            end else begin
              stop_err <= 1'b1;
              rx_state <= RX_WAIT_HIGH;
            end
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        RX_WAIT_HIGH: if (rx) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------- JSON parser ----------------
  typedef enum logic [2:0] {WAIT_OBJ, IN_OBJ, NUM_START, NUM_INT, NUM_FRAC, SKIP_VAL} p_state_t;

  p_state_t                         p_state;
  logic [31:0]                      acc;
  logic                             neg;
  logic [CW-1:0]                    field_cnt;
  logic [FIELDS_N-1:0][VALUE_W-1:0] slots;
  logic                             obj_done;
  logic                             parse_err;

  logic [7:0]         ch;
  logic [3:0]         digit;
  logic               is_digit;
  logic [35:0]        prod;
  logic [31:0]        acc_step;
  logic [31:0]        neg_acc;
  logic [VALUE_W-1:0] commit_val;
  logic               slot_free;

  assign ch        = 8'(rx_byte);
  assign digit     = ch[3:0];
  assign is_digit  = (ch >= "0") && (ch <= "9");
  assign slot_free = (field_cnt != CNT_FULL);

  always_comb begin
    prod     = ({4'd0, acc} << 3) + ({4'd0, acc} << 1) + {32'd0, digit};
    acc_step = (prod > {4'd0, ACC_MAX}) ? ACC_MAX : prod[31:0];
    neg_acc  = -acc;
    if (neg) commit_val = (acc > POS_MAX) ? NEG_MIN : neg_acc[VALUE_W-1:0];
    else     commit_val = (acc > POS_MAX) ? POS_MAX[VALUE_W-1:0] : acc[VALUE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state   <= WAIT_OBJ;
      acc       <= '0;
      neg       <= 1'b0;
      field_cnt <= '0;
      slots     <= '0;
      obj_done  <= 1'b0;
      parse_err <= 1'b0;
    end else begin
      obj_done  <= 1'b0;
      parse_err <= 1'b0;
      if (stop_err) begin
        p_state   <= WAIT_OBJ;
        parse_err <= 1'b1;
      end else if (byte_strobe) begin
        if (ch == "{") begin
          // An opening brace anywhere restarts the object; unwritten slots read back as 0.
          p_state   <= IN_OBJ;
          field_cnt <= '0;
          slots     <= '0;
        end else begin
          case (p_state)
            IN_OBJ: begin
              if (ch == ":") begin
                p_state <= NUM_START;
                acc     <= '0;
                neg     <= 1'b0;
              end else if (ch == "}") begin
                p_state  <= WAIT_OBJ;
                obj_done <= 1'b1;
              end
            end
            NUM_START: begin
              if (ch == "-") begin
                neg     <= 1'b1;
                p_state <= NUM_INT;
              end else if (is_digit) begin
                acc     <= {28'd0, digit};
                p_state <= NUM_INT;
              end else if (ch != " ") begin
                p_state <= SKIP_VAL;
              end
            end
            NUM_INT, NUM_FRAC: begin
              if (is_digit) begin
                if (p_state == NUM_INT) acc <= acc_step;
              end else if (ch == "." && p_state == NUM_INT) begin
                p_state <= NUM_FRAC;
              end else if (ch == "," || ch == "}") begin
                if (slot_free) begin
                  slots[field_cnt] <= commit_val;
                  field_cnt        <= field_cnt + 1'b1;
                end
                p_state  <= (ch == ",") ? IN_OBJ : WAIT_OBJ;
                obj_done <= (ch == "}");
              end else begin
                p_state   <= WAIT_OBJ;
                parse_err <= 1'b1;
              end
            end
            SKIP_VAL: begin
              if (ch == ",") begin
                p_state <= IN_OBJ;
              end else if (ch == "}") begin
                p_state  <= WAIT_OBJ;
                obj_done <= 1'b1;
              end
            end
            default: p_state <= WAIT_OBJ;
          endcase
        end
      end
    end
  end

  // ---------------- Output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      values      <= '0;
      field_count <= '0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid       <= obj_done;
      frame_error <= parse_err;
      if (obj_done) begin
        values      <= slots;
        field_count <= field_cnt;
      end
      if (byte_strobe && ch == "{") busy <= 1'b1;
      else if (obj_done || parse_err) busy <= 1'b0;
    end
  end

endmodule
